// File: rtl/periph_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : periph_pkg
//  Description : Shared definitions for the accumulator-peripheral initiator.
//                Holds the peripheral register addresses and the initiator
//                FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package periph_pkg;

  // Peripheral register map
  localparam logic [1:0] ADDR_CLR    = 2'b00;  // write: clear sum and count
  localparam logic [1:0] ADDR_ADD    = 2'b01;  // write: add word, bump count
  localparam logic [1:0] ADDR_RD_ACC = 2'b10;  // read : accumulated sum
  localparam logic [1:0] ADDR_RD_CNT = 2'b11;  // read : number of adds

  // Initiator FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_PUSH    = 3'd2,
    ST_RD_ACC  = 3'd3,
    ST_CAP_ACC = 3'd4,
    ST_RD_CNT  = 3'd5,
    ST_CAP_CNT = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

endpackage : periph_pkg
`default_nettype wire

// File: rtl/periph_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module      : periph_initiator_if
//  Description : Bundles the input data stream (valid/ready handshake) and
//                the accumulator-peripheral bus. The master modport is the
//                initiator view; the slave modport is the view of whatever
//                sources the stream and implements the peripheral.
//  Revision    : 1.0 - initial release
// ============================================================================
interface periph_initiator_if;

  // Input data stream; a word moves when in_valid && in_ready
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;

  // Peripheral bus
  logic        p_ce;
  logic        p_we;
  logic [1:0]  p_addr;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output p_ce,
    output p_we,
    output p_addr,
    output p_wdata,
    input  p_rdata
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  p_ce,
    input  p_we,
    input  p_addr,
    input  p_wdata,
    output p_rdata
  );

endinterface : periph_initiator_if
`default_nettype wire

// File: rtl/periph_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : periph_initiator
//  Description : Burst initiator for an accumulator peripheral. On start it
//                clears the peripheral, forwards len stream words as add
//                writes while keeping a local shadow sum, reads back the
//                peripheral sum and count, and flags a shadow/readback
//                mismatch together with a one-cycle done pulse.
//  Options     : PERIPH_INIT_TIMEOUT_EN - when defined, TIMEOUT_CYC idle
//                PUSH cycles abort the burst and raise timeout_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module periph_initiator
  import periph_pkg::*;
#(
  parameter int LEN_W       = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              start,
  input  wire logic [LEN_W-1:0]  len,
  periph_initiator_if.master     bus,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            result_acc,
  output logic [31:0]            result_count,
  output logic                   acc_mismatch
`ifdef PERIPH_INIT_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  // --------------------------------------------------------------------------
  // Parameter sanity: a zero-length timeout window would abort every burst
  // --------------------------------------------------------------------------
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("periph_initiator: TIMEOUT_CYC must be at least 1");
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_remain;
  logic [31:0]        r_shadow;
  logic [31:0]        r_result_acc;
  logic [31:0]        r_result_count;
  logic               r_mismatch;

  // Combinational bus drive
  logic               w_xfer;
  logic               w_in_ready;
  logic               w_p_ce;
  logic               w_p_we;
  logic [1:0]         w_p_addr;
  logic [31:0]        w_p_wdata;
  logic               w_timeout_hit;

`ifdef PERIPH_INIT_TIMEOUT_EN
  localparam int unsigned c_TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

  logic [c_TO_W-1:0]  r_idle_cnt;
  logic               r_timeout_err;

  // The current idle PUSH cycle is the last one allowed
  assign w_timeout_hit = (r_state == ST_PUSH) && !bus.in_valid &&
                         (r_idle_cnt == c_TO_LAST);
`else
  assign w_timeout_hit = 1'b0;
`endif

  // A stream word is consumed only while pushing
  assign w_xfer = (r_state == ST_PUSH) && bus.in_valid;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and bus decode; peripheral is idle unless a state claims it
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_p_ce     = 1'b0;
    w_p_we     = 1'b0;
    w_p_addr   = ADDR_CLR;
    w_p_wdata  = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_p_ce   = 1'b1;
        w_p_we   = 1'b1;
        w_p_addr = ADDR_CLR;
        w_next   = (r_remain == '0) ? ST_RD_ACC : ST_PUSH;
      end
      ST_PUSH: begin
        w_in_ready = 1'b1;
        w_p_we     = 1'b1;
        w_p_addr   = ADDR_ADD;
        if (w_xfer) begin
          // Chip enable only qualifies real transfers so gaps issue no writes
          w_p_ce    = 1'b1;
          w_p_wdata = bus.in_data;
          if (r_remain == LEN_W'(1)) begin
            w_next = ST_RD_ACC;
          end
        end else if (w_timeout_hit) begin
          w_next = ST_RD_ACC;
        end
      end
      ST_RD_ACC: begin
        w_p_ce   = 1'b1;
        w_p_addr = ADDR_RD_ACC;
        w_next   = ST_CAP_ACC;
      end
      ST_CAP_ACC: begin
        // Address held so the peripheral's registered read data is stable
        w_p_ce   = 1'b1;
        w_p_addr = ADDR_RD_ACC;
        w_next   = ST_RD_CNT;
      end
      ST_RD_CNT: begin
        w_p_ce   = 1'b1;
        w_p_addr = ADDR_RD_CNT;
        w_next   = ST_CAP_CNT;
      end
      ST_CAP_CNT: begin
        w_p_ce   = 1'b1;
        w_p_addr = ADDR_RD_CNT;
        w_next   = ST_DONE;
      end
      ST_DONE: begin
        // start is deliberately not looked at here
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Burst bookkeeping, shadow sum and readback capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_remain       <= '0;
      r_shadow       <= 32'd0;
      r_result_acc   <= 32'd0;
      r_result_count <= 32'd0;
      r_mismatch     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_remain <= len;
            r_shadow <= 32'd0;
          end
        end
        ST_PUSH: begin
          if (w_xfer) begin
            r_remain <= r_remain - LEN_W'(1);
            r_shadow <= r_shadow + bus.in_data;
          end
        end
        ST_CAP_ACC: begin
          // Compare against the raw read data so the flag is ready for DONE
          r_result_acc <= bus.p_rdata;
          r_mismatch   <= (r_shadow != bus.p_rdata);
        end
        ST_CAP_CNT: begin
          r_result_count <= bus.p_rdata;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef PERIPH_INIT_TIMEOUT_EN
  // Idle-cycle watchdog for PUSH; sticky error cleared by the next start
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (start) begin
        r_idle_cnt    <= '0;
        r_timeout_err <= 1'b0;
      end
    end else if (r_state == ST_PUSH) begin
      if (w_xfer) begin
        r_idle_cnt <= '0;
      end else if (w_timeout_hit) begin
        r_idle_cnt    <= '0;
        r_timeout_err <= 1'b1;
      end else begin
        r_idle_cnt <= r_idle_cnt + c_TO_W'(1);
      end
    end
  end

  assign timeout_err = r_timeout_err;
`endif

  // Output drive
  assign bus.in_ready  = w_in_ready;
  assign bus.p_ce      = w_p_ce;
  assign bus.p_we      = w_p_we;
  assign bus.p_addr    = w_p_addr;
  assign bus.p_wdata   = w_p_wdata;

  assign busy          = (r_state != ST_IDLE);
  assign done          = (r_state == ST_DONE);
  assign result_acc    = r_result_acc;
  assign result_count  = r_result_count;
  assign acc_mismatch  = r_mismatch;

endmodule : periph_initiator
`default_nettype wire

// File: tb/tb_periph_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_periph_initiator
//  Description : Self-checking bench for periph_initiator with a behavioural
//                accumulator peripheral and a scoreboard of expected burst
//                results. Timeout scenario runs when PERIPH_INIT_TIMEOUT_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_periph_initiator;
  import periph_pkg::*;

  localparam int LEN_W       = 5;
  localparam int TIMEOUT_CYC = 255;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic [31:0]       result_acc;
  logic [31:0]       result_count;
  logic              acc_mismatch;
`ifdef PERIPH_INIT_TIMEOUT_EN
  logic              timeout_err;
`endif

  periph_initiator_if u_if ();

  periph_initiator #(
    .LEN_W       (LEN_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .len          (len),
    .bus          (u_if),
    .busy         (busy),
    .done         (done),
    .result_acc   (result_acc),
    .result_count (result_count),
    .acc_mismatch (acc_mismatch)
`ifdef PERIPH_INIT_TIMEOUT_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Peripheral model and bus monitors
  logic [31:0] m_acc = 32'd0;
  logic [31:0] m_cnt = 32'd0;
  bit          corrupt = 1'b0;
  int          n_add  = 0;
  int          n_done = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_acc         <= 32'd0;
      m_cnt         <= 32'd0;
      u_if.p_rdata  <= 32'd0;
    end else if (u_if.p_ce) begin
      if (u_if.p_we) begin
        if (u_if.p_addr == ADDR_CLR) begin
          m_acc <= 32'd0;
          m_cnt <= 32'd0;
        end else if (u_if.p_addr == ADDR_ADD) begin
          m_acc <= m_acc + u_if.p_wdata;
          m_cnt <= m_cnt + 32'd1;
        end
      end else begin
        u_if.p_rdata <= (u_if.p_addr == ADDR_RD_ACC) ? (corrupt ? 32'd0 : m_acc) : m_cnt;
      end
    end
    if (u_if.p_ce && u_if.p_we && u_if.p_addr == ADDR_ADD) n_add <= n_add + 1;
    if (done) n_done <= n_done + 1;
  end

  // Scoreboard
  typedef struct {
    logic [31:0] acc;
    logic [31:0] cnt;
    logic        mis;
    logic        terr;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one burst: n = len, n_send words actually offered, gap idle cycles
  // after each transfer. exp_lat < 0 skips the latency check.
  task automatic run_burst(input int n, input int n_send, input int gap,
                           input logic [31:0] w [4], input bit corr,
                           input int exp_lat, input bit exp_terr,
                           output int rdy);
    exp_t        e;
    logic [31:0] sum;
    int          cyc, idx, gapcnt, add0;
    bit          got, xfer;
    sum = 32'd0;
    for (int i = 0; i < n_send; i++) sum = sum + w[i];
    e.acc  = corr ? 32'd0 : sum;
    e.cnt  = 32'(n_send);
    e.mis  = corr ? (sum != 32'd0) : 1'b0;
    e.terr = exp_terr;
    e.lat  = exp_lat;
    sb.push_back(e);

    corrupt = corr;
    add0    = n_add;
    rdy     = 0;
    start   = 1'b1;
    len     = LEN_W'(n);
    @(posedge clk); #1;
    start  = 1'b0;
    cyc    = 1;
    idx    = 0;
    gapcnt = 0;
    got    = 1'b0;
    while (!got && cyc < 2000) begin
      if (idx < n_send && gapcnt == 0) begin
        u_if.in_valid = 1'b1;
        u_if.in_data  = w[idx];
      end else begin
        u_if.in_valid = 1'b0;
        u_if.in_data  = 32'hDEAD_BEEF;
      end
      #1;
      xfer = u_if.in_valid && u_if.in_ready;
      if (u_if.in_ready) begin
        rdy++;
        chk("push_p_ce", {31'd0, u_if.p_ce}, {31'd0, u_if.in_valid});
      end
      @(posedge clk); #1;
      cyc++;
      if (xfer) begin
        idx++;
        gapcnt = gap;
      end else if (gapcnt > 0) begin
        gapcnt--;
      end
      if (done) begin
        got = 1'b1;
        e = sb.pop_front();
        chk("result_acc", result_acc, e.acc);
        chk("result_count", result_count, e.cnt);
        chk("acc_mismatch", {31'd0, acc_mismatch}, {31'd0, e.mis});
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        if (e.lat >= 0) chk("latency", 32'(cyc), 32'(e.lat));
`ifdef PERIPH_INIT_TIMEOUT_EN
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, e.terr});
`endif
        // start offered during DONE must be ignored
        u_if.in_valid = 1'b0;
        start = 1'b1;
        len   = LEN_W'(1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("hold_acc", result_acc, e.acc);
        chk("hold_count", result_count, e.cnt);
        chk("hold_done_low", {31'd0, done}, 32'd0);
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("add_writes", 32'(n_add - add0), 32'(n_send));
  endtask

  initial begin
    logic [31:0] wv [4];
    int          rdy, d0;

    reset         = 1'b1;
    start         = 1'b0;
    len           = '0;
    u_if.in_valid = 1'b0;
    u_if.in_data  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_acc", result_acc, 32'd0);
    chk("rst_count", result_count, 32'd0);
    chk("rst_mismatch", {31'd0, acc_mismatch}, 32'd0);
    chk("rst_p_ce", {31'd0, u_if.p_ce}, 32'd0);
    chk("rst_in_ready", {31'd0, u_if.in_ready}, 32'd0);
`ifdef PERIPH_INIT_TIMEOUT_EN
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
`endif

    // Three words back-to-back
    wv = '{32'd5, 32'd7, 32'd9, 32'd0};
    run_burst(3, 3, 0, wv, 1'b0, 9, 1'b0, rdy);

    // Zero-length burst: no PUSH at all
    wv = '{32'd0, 32'd0, 32'd0, 32'd0};
    run_burst(0, 0, 0, wv, 1'b0, 6, 1'b0, rdy);
    chk("len0_in_ready_cycles", 32'(rdy), 32'd0);

    // Two words with 3-cycle gaps
    wv = '{32'h0000_0100, 32'h0000_0023, 32'd0, 32'd0};
    run_burst(2, 2, 3, wv, 1'b0, -1, 1'b0, rdy);

    // Wrapping sum, peripheral reads back 0
    wv = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0};
    run_burst(2, 2, 0, wv, 1'b1, 8, 1'b0, rdy);

    // Reset in the second PUSH cycle
    corrupt = 1'b0;
    d0    = n_done;
    start = 1'b1;
    len   = LEN_W'(3);
    @(posedge clk); #1;
    start         = 1'b0;
    u_if.in_valid = 1'b1;
    u_if.in_data  = 32'd11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_p_ce", {31'd0, u_if.p_ce}, 32'd0);
    chk("abort_acc", result_acc, 32'd0);
    chk("abort_count", result_count, 32'd0);
    chk("abort_mismatch", {31'd0, acc_mismatch}, 32'd0);
    u_if.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(n_done - d0), 32'd0);

    // Recovery burst after the abort
    wv = '{32'h1234_5678, 32'd0, 32'd0, 32'd0};
    run_burst(1, 1, 0, wv, 1'b0, 7, 1'b0, rdy);

`ifdef PERIPH_INIT_TIMEOUT_EN
    // One word of four, then the stream stalls
    wv = '{32'h0000_00AB, 32'd1, 32'd2, 32'd3};
    run_burst(4, 1, 0, wv, 1'b0, 1 + 1 + TIMEOUT_CYC + 5, 1'b1, rdy);
`endif

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_periph_initiator
`default_nettype wire
